// File: rtl/hzd_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard and its bypass selector.
package hzd_scoreboard_pkg;

  typedef logic bool_t;

  localparam int         XLEN_DEF  = 32;
  localparam int         CNT_W_DEF = 2;
  localparam logic [4:0] REG_X0    = 5'd0;

  typedef struct packed {
    bool_t               valid;
    logic [4:0]          rd;
    bool_t               rdy;
    logic [XLEN_DEF-1:0] data;
  } byp_port_t;

endpackage

// File: rtl/hzd_scoreboard_byp_select.sv
// Combinational priority mux for one source operand: the lowest-index (youngest) matching stage wins.
module hzd_scoreboard_byp_select
  import hzd_scoreboard_pkg::*;
#(
  parameter int  XLEN    = XLEN_DEF,
  parameter int  NUM_BYP = 3,
  parameter type port_t  = byp_port_t
) (
  input  logic [4:0]      rs,
  input  port_t           byp [NUM_BYP],
  output bool_t           hit,
  output bool_t           rdy,
  output logic [XLEN-1:0] data
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp[i].valid && (byp[i].rd == rs)) begin
        hit  = 1'b1;
        rdy  = byp[i].rdy;
        data = byp[i].data;
      end
    end
  end

endmodule

// File: rtl/hzd_scoreboard.sv
// Per-register in-flight write scoreboard with bypass resolution, issue stall and stall-cycle counter.
module hzd_scoreboard
  import hzd_scoreboard_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_RS  = 2,
  parameter int NUM_BYP = 3,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           iss_valid,
  input  logic                           iss_has_rd,
  input  logic [4:0]                     iss_rd,
  input  logic [NUM_RS-1:0]              iss_has_rs,
  input  logic [NUM_RS-1:0][4:0]         iss_rs,
  output logic                           iss_stall,
  output logic [NUM_RS-1:0]              fwd_valid,
  output logic [NUM_RS-1:0][XLEN-1:0]    fwd_data,
  input  logic [NUM_BYP-1:0]             byp_valid,
  input  logic [NUM_BYP-1:0][4:0]        byp_rd,
  input  logic [NUM_BYP-1:0]             byp_rdy,
  input  logic [NUM_BYP-1:0][XLEN-1:0]   byp_data,
  input  logic                           ret_valid,
  input  logic [4:0]                     ret_rd,
  input  logic                           flush,
  output logic [31:0]                    stall_cnt
);

  typedef struct packed {
    bool_t           valid;
    logic [4:0]      rd;
    bool_t           rdy;
    logic [XLEN-1:0] data;
  } byp_t;

  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [31:0]            inc_vec, dec_vec;

  byp_t                   byp [NUM_BYP];
  logic [NUM_RS-1:0]      sel_hit, sel_rdy, op_haz, op_stall;
  logic [NUM_RS-1:0][XLEN-1:0] sel_data;
  logic                   rd_sat, fire;

  always_comb begin
    for (int i = 0; i < NUM_BYP; i++) begin
      byp[i] = '{valid: byp_valid[i], rd: byp_rd[i], rdy: byp_rdy[i], data: byp_data[i]};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_sel
      hzd_scoreboard_byp_select #(
        .XLEN    (XLEN),
        .NUM_BYP (NUM_BYP),
        .port_t  (byp_t)
      ) u_sel (
        .rs   (iss_rs[gi]),
        .byp  (byp),
        .hit  (sel_hit[gi]),
        .rdy  (sel_rdy[gi]),
        .data (sel_data[gi])
      );
    end
  endgenerate

  always_comb begin
    op_haz    = '0;
    op_stall  = '0;
    fwd_valid = '0;
    fwd_data  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      op_haz[k] = iss_has_rs[k] && (iss_rs[k] != REG_X0) && (cnt_q[iss_rs[k]] != '0);
      if (en && op_haz[k]) begin
        if (sel_hit[k] && sel_rdy[k]) begin
          fwd_valid[k] = 1'b1;
          fwd_data[k]  = sel_data[k];
        end else begin
          op_stall[k] = 1'b1;
        end
      end
    end
    rd_sat    = iss_has_rd && (iss_rd != REG_X0) && (cnt_q[iss_rd] == '1);
    iss_stall = en && iss_valid && ((|op_stall) || rd_sat);
  end

  // A same-cycle fire and retire on one register cancel out.
  always_comb begin
    fire        = en && iss_valid && !iss_stall;
    inc_vec     = '0;
    dec_vec     = '0;
    cnt_d       = cnt_q;
    cnt_d[0]    = '0;
    stall_cnt_d = stall_cnt_q + 32'(iss_stall);
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = fire && iss_has_rd && (iss_rd == 5'(r));
      dec_vec[r] = en && ret_valid && (ret_rd == 5'(r));
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // Retiring a register with nothing in flight is a protocol error.
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    (en && ret_valid && (ret_rd != REG_X0)) |-> ((cnt_q[ret_rd] != '0) || inc_vec[ret_rd]));

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Directed vector table, random stimulus against a behavioural scoreboard model, and async reset check.
module tb_hzd_scoreboard;

  localparam int XLEN = 32, NUM_RS = 2, NUM_BYP = 3, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                          clk, rst_n, en, iss_valid, iss_has_rd, ret_valid, flush;
  logic [4:0]                    iss_rd, ret_rd;
  logic [NUM_RS-1:0]             iss_has_rs;
  logic [NUM_RS-1:0][4:0]        iss_rs;
  logic                          iss_stall;
  logic [NUM_RS-1:0]             fwd_valid;
  logic [NUM_RS-1:0][XLEN-1:0]   fwd_data;
  logic [NUM_BYP-1:0]            byp_valid, byp_rdy;
  logic [NUM_BYP-1:0][4:0]       byp_rd;
  logic [NUM_BYP-1:0][XLEN-1:0]  byp_data;
  logic [31:0]                   stall_cnt;

  hzd_scoreboard #(.XLEN(XLEN), .NUM_RS(NUM_RS), .NUM_BYP(NUM_BYP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iss_valid(iss_valid), .iss_has_rd(iss_has_rd),
    .iss_rd(iss_rd), .iss_has_rs(iss_has_rs), .iss_rs(iss_rs), .iss_stall(iss_stall),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_rdy(byp_rdy), .byp_data(byp_data), .ret_valid(ret_valid), .ret_rd(ret_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             en, iv, hrd;
    logic [4:0]       rd;
    logic [1:0]       hrs;
    logic [4:0]       rs0, rs1;
    logic [2:0]       bv, brdy;
    logic [2:0][4:0]  brd;
    logic [2:0][31:0] bd;
    logic             rv;
    logic [4:0]       rr;
    logic             fl, es;
    logic [1:0]       efv;
    logic [31:0]      efd0, efd1;
  } vec_t;

  int unsigned n_vec = 0, n_err = 0, cyc = 0;
  int          cnt_m [32];
  logic [31:0] stall_m;
  logic        e_stall;
  logic [1:0]  e_fv;
  logic [1:0][31:0] e_fd;
  vec_t        tbl [$];

  function automatic vec_t mk(int en_i, int iv, int hrd, int rd, int hrs, int rs0, int rs1,
                              int rv, int rr, int fl, int es, int efv, int efd0, int efd1);
    vec_t v;
    v = '0;
    v.en = 1'(en_i); v.iv = 1'(iv); v.hrd = 1'(hrd); v.rd = 5'(rd);
    v.hrs = 2'(hrs); v.rs0 = 5'(rs0); v.rs1 = 5'(rs1);
    v.rv = 1'(rv); v.rr = 5'(rr); v.fl = 1'(fl);
    v.es = 1'(es); v.efv = 2'(efv); v.efd0 = 32'(efd0); v.efd1 = 32'(efd1);
    return v;
  endfunction

  function automatic vec_t byp(vec_t v, int s, int rd, int rdy, int d);
    v.bv[s] = 1'b1; v.brd[s] = 5'(rd); v.brdy[s] = 1'(rdy); v.bd[s] = 32'(d);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: hazard if the source has writes in flight; youngest matching stage supplies it.
  task automatic model_eval();
    logic any_stall;
    int   m;
    any_stall = 1'b0; e_fv = '0; e_fd = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      m = -1;
      for (int i = 0; i < NUM_BYP; i++)
        if (m < 0 && byp_valid[i] && byp_rd[i] == iss_rs[k]) m = i;
      if (en && iss_has_rs[k] && iss_rs[k] != 0 && cnt_m[iss_rs[k]] > 0) begin
        if (m >= 0 && byp_rdy[m]) begin
          e_fv[k] = 1'b1;
          e_fd[k] = byp_data[m];
        end else begin
          any_stall = 1'b1;
        end
      end
    end
    e_stall = en && iss_valid && (any_stall || (iss_has_rd && iss_rd != 0 && cnt_m[iss_rd] == CMAX));
  endtask

  task automatic model_update();
    logic fire;
    int   d;
    fire = en && iss_valid && !e_stall;
    for (int r = 1; r < 32; r++) begin
      d = cnt_m[r] + int'(fire && iss_has_rd && iss_rd == 5'(r)) - int'(en && ret_valid && ret_rd == 5'(r));
      cnt_m[r] = flush ? 0 : (d < 0 ? 0 : d);
    end
    stall_m = stall_m + 32'(e_stall);
  endtask

  task automatic step(input string tag);
    #1;
    model_eval();
    check("iss_stall", 32'(iss_stall), 32'(e_stall));
    check("fwd_valid", 32'(fwd_valid), 32'(e_fv));
    check("fwd_data0", fwd_data[0], e_fd[0]);
    check("fwd_data1", fwd_data[1], e_fd[1]);
    check("stall_cnt", stall_cnt, stall_m);
    $display("%s cyc=%0d stall=%0b fv=%b fd0=%h fd1=%h stall_cnt=%0d",
             tag, cyc, iss_stall, fwd_valid, fwd_data[0], fwd_data[1], stall_cnt);
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    en = 1'b1; iss_valid = 1'b0; iss_has_rd = 1'b0; iss_rd = '0; iss_has_rs = '0; iss_rs = '0;
    byp_valid = '0; byp_rd = '0; byp_rdy = '0; byp_data = '0;
    ret_valid = 1'b0; ret_rd = '0; flush = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    en = v.en; iss_valid = v.iv; iss_has_rd = v.hrd; iss_rd = v.rd;
    iss_has_rs = v.hrs; iss_rs[0] = v.rs0; iss_rs[1] = v.rs1;
    byp_valid = v.bv; byp_rd = v.brd; byp_rdy = v.brdy; byp_data = v.bd;
    ret_valid = v.rv; ret_rd = v.rr; flush = v.fl;
    #1;
    check("tbl_stall", 32'(iss_stall), 32'(v.es));
    check("tbl_fwd_valid", 32'(fwd_valid), 32'(v.efv));
    check("tbl_fwd_data0", fwd_data[0], v.efd0);
    check("tbl_fwd_data1", fwd_data[1], v.efd1);
    step("vec");
  endtask

  initial begin
    // Back-to-back ALU dependence
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,5, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(byp(mk(1,1,0,0, 1,5,0, 0,0,0, 0,1,'h1234,0), 0,5,1,'h1234));
    // Load-use: two stall cycles, then the load data arrives
    tbl.push_back(mk(1,1,1,7, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(byp(mk(1,1,0,0, 2,0,7, 0,0,0, 1,0,0,0), 0,7,0,0));
    tbl.push_back(byp(mk(1,1,0,0, 2,0,7, 0,0,0, 1,0,0,0), 0,7,0,0));
    tbl.push_back(byp(mk(1,1,0,0, 2,0,7, 0,0,0, 0,2,0,'hBEEF), 0,7,1,'hBEEF));
    // Youngest writer wins
    tbl.push_back(mk(1,1,1,3, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,3, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(byp(byp(mk(1,1,0,0, 1,3,0, 0,0,0, 0,1,'hA,0), 0,3,1,'hA), 2,3,1,'hB));
    // Saturation on x9
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 1,9,0, 1,0,0,0));
    tbl.push_back(mk(1,1,1,9, 0,0,0, 0,0,0, 0,0,0,0));
    // Simultaneous fire/retire, then with flush
    tbl.push_back(mk(1,1,1,4, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,4, 0,0,0, 1,4,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 1,4,0, 0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,1,4, 0,0,0, 1,4,1, 0,0,0,0));
    tbl.push_back(mk(1,1,1,9, 3,4,9, 0,0,0, 0,0,0,0));
    // Disabled block, writeback forwarding window, x0 never hazarded
    tbl.push_back(mk(1,1,1,6, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(byp(mk(0,1,0,0, 1,6,0, 0,0,0, 0,0,0,0), 0,6,1,'h77));
    tbl.push_back(byp(mk(1,1,0,0, 1,6,0, 0,0,0, 0,1,'h77,0), 0,6,1,'h77));
    tbl.push_back(byp(mk(1,1,0,0, 1,6,0, 1,6,0, 0,1,'h66,0), 2,6,1,'h66));
    tbl.push_back(mk(1,1,0,0, 1,6,0, 0,0,0, 0,0,0,0));
    tbl.push_back(byp(mk(1,1,1,0, 1,0,0, 0,0,0, 0,0,0,0), 0,0,1,'h55));

    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    stall_m = '0;
    set_idle();
    rst_n = 1'b0;
    iss_valid = 1'b1; iss_has_rs = 2'b11; iss_rs[0] = 5'd5; iss_rs[1] = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(iss_stall), 32'd0);
    check("reset_fwd_valid", 32'(fwd_valid), 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    foreach (tbl[i]) apply_vec(tbl[i]);

    for (int n = 0; n < 1500; n++) begin
      int rr;
      set_idle();
      en         = ($urandom_range(15) != 0);
      iss_valid  = ($urandom_range(3) != 0);
      iss_has_rd = $urandom_range(1);
      iss_rd     = 5'($urandom_range(7));
      iss_has_rs = 2'($urandom_range(3));
      iss_rs[0]  = 5'($urandom_range(7));
      iss_rs[1]  = 5'($urandom_range(7));
      for (int i = 0; i < NUM_BYP; i++) begin
        byp_valid[i] = $urandom_range(1);
        byp_rd[i]    = 5'($urandom_range(7));
        byp_rdy[i]   = $urandom_range(1);
        byp_data[i]  = $urandom;
      end
      rr = $urandom_range(1, 7);
      if (cnt_m[rr] > 0 && $urandom_range(1) == 1) begin
        ret_valid = 1'b1;
        ret_rd    = 5'(rr);
      end
      flush = en && ($urandom_range(63) == 0);
      step("rnd");
    end

    // Async reset between edges discards in-flight state at once
    set_idle(); flush = 1'b1; step("seq");
    set_idle(); iss_valid = 1'b1; iss_has_rd = 1'b1; iss_rd = 5'd6; step("seq");
    step("seq");
    set_idle(); iss_valid = 1'b1; iss_has_rs = 2'b01; iss_rs[0] = 5'd6;
    repeat (4) step("seq");
    #2;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    stall_m = '0;
    check("async_stall_cnt", stall_cnt, 32'd0);
    check("async_stall", 32'(iss_stall), 32'd0);
    check("async_fwd_valid", 32'(fwd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("seq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
